pc_debug_reg: RTL and testbench

Debug capture register for the single-cycle RISC-V core's program counter. Each enabled clock edge registers the current PC onto o_pc_debug, for the testbench/debug port. It also provides a valid flag, a retired-instruction counter, a one-entry previous-PC register and a single PC breakpoint comparator. The block sits beside the PC register in the top level and has no effect on the datapath.

---
 rtl/core_pkg.sv | 9 +
 rtl/dbg_counter.sv | 26 ++
 rtl/pc_debug_reg.sv | 61 ++++++
 tb/tb_pc_debug_reg.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, reset PC and address type
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/dbg_counter.sv
// rtl/dbg_counter.sv - synchronous-clear, enabled, wrapping counter
//
// Ports:
//   i_clk  - clock, count updates on the rising edge
//   i_clr  - synchronous clear to zero, overrides i_en
//   i_en   - increment enable
//   o_cnt  - current count, wraps modulo 2^W
module dbg_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      // Natural overflow gives the all-ones -> zero wrap.
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/pc_debug_reg.sv
// rtl/pc_debug_reg.sv - registered PC capture with previous PC, retire count and breakpoint
//
// Ports:
//   i_clk        - clock, all state updates on the rising edge
//   i_rst        - synchronous active-high reset, highest priority
//   i_pc         - current PC from the core
//   i_en         - capture enable (instruction retires this cycle)
//   i_bp_en      - breakpoint compare enable
//   i_bp_addr    - breakpoint PC
//   o_pc_debug   - PC captured at the last enabled edge
//   o_pc_prev    - o_pc_debug value before its last update
//   o_pc_valid   - at least one capture since reset
//   o_retire_cnt - captures since reset, wrapping
//   o_bp_hit     - registered breakpoint match for the last edge
module pc_debug_reg
  import core_pkg::*;
#(
  parameter int unsigned       WIDTH     = XLEN,
  parameter logic [WIDTH-1:0]  RESET_PC  = WIDTH'(PC_RESET),
  parameter int unsigned       CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_pc,
  input  logic                 i_en,
  input  logic                 i_bp_en,
  input  logic [WIDTH-1:0]     i_bp_addr,
  output logic [WIDTH-1:0]     o_pc_debug,
  output logic [WIDTH-1:0]     o_pc_prev,
  output logic                 o_pc_valid,
  output logic [CNT_WIDTH-1:0] o_retire_cnt,
  output logic                 o_bp_hit
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc_debug <= RESET_PC;
      o_pc_prev  <= RESET_PC;
      o_pc_valid <= 1'b0;
      o_bp_hit   <= 1'b0;
    end else if (i_en) begin
      o_pc_prev  <= o_pc_debug;
      o_pc_debug <= i_pc;
      o_pc_valid <= 1'b1;
      o_bp_hit   <= i_bp_en && (i_pc == i_bp_addr);
    end else begin
      // Hit is a per-retirement pulse, so it drops on idle cycles.
      o_bp_hit   <= 1'b0;
    end
  end

  dbg_counter #(
    .W (CNT_WIDTH)
  ) u_retire_cnt (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_en  (i_en),
    .o_cnt (o_retire_cnt)
  );

endmodule

// File: tb/tb_pc_debug_reg.sv
// tb/tb_pc_debug_reg.sv - self-checking bench for pc_debug_reg
module tb_pc_debug_reg;
  import core_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        bp_en;
  addr_t       pc;
  addr_t       bp_addr;

  addr_t       pc_debug, pc_prev;
  logic        pc_valid, bp_hit;
  logic [31:0] retire_cnt;

  addr_t       pc_debug4, pc_prev4;
  logic        pc_valid4, bp_hit4;
  logic [3:0]  retire_cnt4;

  pc_debug_reg dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc         (pc),
    .i_en         (en),
    .i_bp_en      (bp_en),
    .i_bp_addr    (bp_addr),
    .o_pc_debug   (pc_debug),
    .o_pc_prev    (pc_prev),
    .o_pc_valid   (pc_valid),
    .o_retire_cnt (retire_cnt),
    .o_bp_hit     (bp_hit)
  );

  pc_debug_reg #(.CNT_WIDTH(4)) dut4 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc         (pc),
    .i_en         (en),
    .i_bp_en      (bp_en),
    .i_bp_addr    (bp_addr),
    .o_pc_debug   (pc_debug4),
    .o_pc_prev    (pc_prev4),
    .o_pc_valid   (pc_valid4),
    .o_retire_cnt (retire_cnt4),
    .o_bp_hit     (bp_hit4)
  );

  // Reference model state
  longint unsigned m_debug, m_prev, m_cnt;
  bit              m_valid, m_bp;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":pc_debug"},  {32'h0, pc_debug},     m_debug);
    check({tag, ":pc_prev"},   {32'h0, pc_prev},      m_prev);
    check({tag, ":valid"},     {63'h0, pc_valid},     {63'h0, m_valid});
    check({tag, ":cnt"},       {32'h0, retire_cnt},   m_cnt % 64'h1_0000_0000);
    check({tag, ":bp_hit"},    {63'h0, bp_hit},       {63'h0, m_bp});
    check({tag, ":cnt4"},      {60'h0, retire_cnt4},  m_cnt % 16);
    check({tag, ":valid4"},    {63'h0, pc_valid4},    {63'h0, m_valid});
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit r, input bit e, input addr_t p,
                      input bit be, input addr_t ba);
    rst = r; en = e; pc = p; bp_en = be; bp_addr = ba;
    @(posedge clk);
    if (r) begin
      m_debug = 0; m_prev = 0; m_valid = 0; m_cnt = 0; m_bp = 0;
    end else if (e) begin
      m_prev  = m_debug;
      m_debug = p;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
      m_bp    = be && (p == ba);
    end else begin
      m_bp = 0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    addr_t rp, rba;
    bit    rr, re, rbe;

    m_debug = 0; m_prev = 0; m_valid = 0; m_cnt = 0; m_bp = 0;
    rst = 1'b1; en = 1'b0; pc = '0; bp_en = 1'b0; bp_addr = '0;
    @(negedge clk);

    // Reset with capture enabled: reset wins
    step("reset", 1, 1, 32'h1234_5678, 0, 0);

    // Captures
    step("cap1", 0, 1, 32'h1234_5678, 0, 0);
    step("cap2", 0, 1, 32'hA5A5_A5A5, 0, 0);

    // Hold for 3 edges
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 32'hDEAD_BEEF, 0, 0);

    // Reset asserted between edges must not act until the next edge
    rst = 1'b1; en = 1'b1; pc = 32'h0000_0040;
    #2;
    check("async_rst_pc",  {32'h0, pc_debug},   64'hA5A5_A5A5);
    check("async_rst_cnt", {32'h0, retire_cnt}, 64'd2);

    // Reset mid-run, then resume
    step("rst_mid", 1, 1, 32'h0000_0040, 0, 0);
    step("after_rst", 0, 1, 32'h0000_0040, 0, 0);

    // Breakpoint
    step("bp_match",   0, 1, 32'h0000_0010, 1, 32'h0000_0010);
    step("bp_miss",    0, 1, 32'h0000_0014, 1, 32'h0000_0010);
    step("bp_match2",  0, 1, 32'h0000_0010, 1, 32'h0000_0010);
    step("bp_idle",    0, 0, 32'h0000_0010, 1, 32'h0000_0010);
    step("bp_dis",     0, 1, 32'h0000_0010, 0, 32'h0000_0010);
    step("bp_hibit",   0, 1, 32'h8000_0010, 1, 32'h0000_0010);

    // Unaligned PC captured verbatim
    step("unaligned",  0, 1, 32'h0000_0103, 0, 0);

    // Counter wrap on the 4-bit instance
    step("wrap_rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step("wrap", 0, 1, 32'h100 + 4 * i, 0, 0);
    check("wrap_cnt4_zero", {60'h0, retire_cnt4}, 64'd0);
    check("wrap_valid4",    {63'h0, pc_valid4},   64'd1);
    check("wrap_cnt32",     {32'h0, retire_cnt},  64'd16);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rr  = ($urandom_range(0, 39) == 0);
      re  = ($urandom_range(0, 3) != 0);
      rbe = $urandom_range(0, 1);
      rba = $urandom;
      rp  = ($urandom_range(0, 3) == 0) ? rba : addr_t'($urandom);
      step("rand", rr, re, rp, rbe, rba);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
